hazard_ctrl_gen: RTL and testbench

- Parametrised successor of the CPU stall/flush controller.
- Generates per-stage stall and flush vectors for an NSTAGE in-order pipeline (index 0 = IF, 1 = ID, 2 = EX, 3 = MEM, ...).
- Adds hazard handling the previous generation lacked:
  - multi-cycle load-use tracking with x0 exclusion;
  - a multi-cycle EX busy stall;
  - a counted squash of every in-flight instruction fetch after a redirect.
- Sits between the pipeline registers, the branch unit and the instruction/data memory interfaces.

---
 rtl/hazard_ctrl_gen_pkg.sv | 25 ++
 rtl/hazard_ctrl_gen_if.sv | 42 ++++
 rtl/hazard_ctrl_gen_load_scoreboard.sv | 55 +++++
 rtl/hazard_ctrl_gen.sv | 117 +++++++++++
 tb/tb_hazard_ctrl_gen.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_gen_pkg.sv
// Shared definitions for the hazard controller: stage indices, flush encodings
// and the width helper used for the fetch counters.
package hazard_pkg;

   localparam int unsigned IF_S  = 0;
   localparam int unsigned ID_S  = 1;
   localparam int unsigned EX_S  = 2;
   localparam int unsigned MEM_S = 3;

   typedef enum logic [2:0] {
      FLUSH_NONE = 3'b000,
      FLUSH_JUMP = 3'b011,
      FLUSH_INT  = 3'b111
   } flush_e;

   localparam logic [1:0] MEMTOREG_MUX_MEM = 2'd1;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/hazard_ctrl_gen_if.sv
// Pipeline-to-hazard-controller signal bundle; the controller is the slave.
interface hazard_ctrl_gen_if #(
   parameter int unsigned NSTAGE = 5,
   parameter int unsigned REG_AW = 5
);

   logic              jump;
   logic              jump_reg;
   logic              branch;
   logic              int_req;
   logic              ex_load;
   logic [REG_AW-1:0] ex_rd_addr;
   logic [REG_AW-1:0] id_rs1_addr;
   logic [REG_AW-1:0] id_rs2_addr;
   logic [1:0]        id_hazard_op;
   logic              ex_busy;
   logic              instr_issue;
   logic              instr_resp;
   logic              instr_wait;
   logic              data_req;
   logic              data_wait;
   logic [NSTAGE-2:0] stall;
   logic [2:0]        flush;
   logic              ex_bubble;
   logic              fetch_squash;
   logic              issue_ok;

   modport master (
      output jump, jump_reg, branch, int_req, ex_load, ex_rd_addr,
             id_rs1_addr, id_rs2_addr, id_hazard_op, ex_busy,
             instr_issue, instr_resp, instr_wait, data_req, data_wait,
      input  stall, flush, ex_bubble, fetch_squash, issue_ok
   );

   modport slave (
      input  jump, jump_reg, branch, int_req, ex_load, ex_rd_addr,
             id_rs1_addr, id_rs2_addr, id_hazard_op, ex_busy,
             instr_issue, instr_resp, instr_wait, data_req, data_wait,
      output stall, flush, ex_bubble, fetch_squash, issue_ok
   );

endinterface

// File: rtl/hazard_ctrl_gen_load_scoreboard.sv
// Tracks loads that have left EX but whose data is not yet forwardable, and
// flags a load-use hazard against the ID source registers.
module load_scoreboard #(
   parameter  int unsigned LOAD_LAT = 2,
   parameter  int unsigned REG_AW   = 5,
   localparam int unsigned NE       = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_load,
   input  logic              ex_kill,
   input  logic [REG_AW-1:0] ex_rd_addr,
   input  logic [NE-1:0]     hold,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic [1:0]        id_hazard_op,
   output logic              luse
);

   logic [NE-1:0]     v_q;
   logic [NE-1:0]     v_nxt;
   logic [REG_AW-1:0] rd_q   [NE];
   logic [REG_AW-1:0] rd_nxt [NE];
   logic              head_v;

   function automatic logic hit(input logic v, input logic [REG_AW-1:0] rd);
      return v && (rd != '0) &&
             ((id_hazard_op[0] && (rd == id_rs1_addr)) ||
              (id_hazard_op[1] && (rd == id_rs2_addr)));
   endfunction

   // With LOAD_LAT==1 the single entry is never filled, leaving only the EX term.
   always_comb begin
      head_v    = ex_load & ~ex_kill & (LOAD_LAT > 1);
      v_nxt     = (v_q << 1) | NE'(head_v);
      rd_nxt[0] = ex_rd_addr;
      for (int unsigned k = 1; k < NE; k++) rd_nxt[k] = rd_q[k-1];
      luse = hit(ex_load, ex_rd_addr);
      for (int unsigned k = 0; k < NE; k++) luse = luse | hit(v_q[k], rd_q[k]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
      end else begin
         for (int unsigned k = 0; k < NE; k++) begin
            if (!hold[k]) begin
               v_q[k]  <= v_nxt[k];
               rd_q[k] <= rd_nxt[k];
            end
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl_gen.sv
// Per-stage stall/flush generation for an NSTAGE in-order pipeline, with
// load-use tracking, EX busy stall and counted wrong-path fetch squashing.
module hazard_ctrl_gen
   import hazard_pkg::*;
#(
   parameter int unsigned NSTAGE    = 5,
   parameter int unsigned REG_AW    = 5,
   parameter int unsigned LOAD_LAT  = 2,
   parameter int unsigned MAX_OUTST = 2
) (
   input logic              clk,
   input logic              rst,
   hazard_ctrl_gen_if.slave bus
);

   localparam int unsigned SW = NSTAGE - 1;
   localparam int unsigned CW = clog2(MAX_OUTST + 1);
   localparam int unsigned NE = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
   localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);

   logic          quiet_q;
   logic          quiet;
   logic          jump_event;
   logic          dstall;
   logic          luse;
   flush_e        raw_flush;
   logic [2:0]    flush_c;
   logic [SW-1:0] stall_c;
   logic          ex_bubble_c;
   logic          fetch_squash_c;
   logic [CW-1:0] outst_cnt;
   logic [CW-1:0] squash_cnt;
   logic [CW-1:0] cnt_nxt;
   logic [NE-1:0] sb_hold;

   // Outputs stay quiet during reset and the cycle after it.
   always_comb begin
      quiet      = rst | quiet_q;
      jump_event = bus.jump | bus.jump_reg | bus.branch;
      dstall     = bus.data_req & bus.data_wait;
      cnt_nxt    = outst_cnt + CW'(bus.instr_issue) - CW'(bus.instr_resp);

      if (bus.int_req)     raw_flush = FLUSH_INT;
      else if (jump_event) raw_flush = FLUSH_JUMP;
      else                 raw_flush = FLUSH_NONE;

      flush_c = '0;
      if (!quiet && !dstall) flush_c = raw_flush;

      stall_c = '0;
      if (!quiet) begin
         if (dstall)
            stall_c = '1;
         else if (bus.ex_busy)
            stall_c[EX_S:IF_S] = '1;
         else if (luse || (!jump_event && bus.instr_wait))
            stall_c[ID_S:IF_S] = '1;
         else if (!jump_event && ((squash_cnt != '0) || bus.instr_wait))
            stall_c[IF_S] = 1'b1;
      end

      ex_bubble_c    = ~quiet & luse & ~bus.ex_busy & ~dstall;
      fetch_squash_c = ~quiet & bus.instr_resp & ((squash_cnt != '0) | flush_c[IF_S]);
   end

   // Entry k follows the stage k+2 hold; stages past the last stall bit never hold.
   for (genvar k = 0; k < NE; k++) begin : g_hold
      if (k + 2 < SW) begin : g_stage
         assign sb_hold[k] = stall_c[k+2];
      end else begin : g_free
         assign sb_hold[k] = 1'b0;
      end
   end

   load_scoreboard #(
      .LOAD_LAT (LOAD_LAT),
      .REG_AW   (REG_AW)
   ) u_load_scoreboard (
      .clk          (clk),
      .rst          (rst),
      .ex_load      (bus.ex_load),
      .ex_kill      (flush_c[EX_S]),
      .ex_rd_addr   (bus.ex_rd_addr),
      .hold         (sb_hold),
      .id_rs1_addr  (bus.id_rs1_addr),
      .id_rs2_addr  (bus.id_rs2_addr),
      .id_hazard_op (bus.id_hazard_op),
      .luse         (luse)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         quiet_q    <= 1'b1;
         outst_cnt  <= '0;
         squash_cnt <= '0;
      end else begin
         quiet_q   <= 1'b0;
         outst_cnt <= cnt_nxt;
         if (flush_c[IF_S])
            squash_cnt <= cnt_nxt;
         else if (bus.instr_resp && (squash_cnt != '0))
            squash_cnt <= squash_cnt - 1'b1;
      end
   end

   assign bus.stall        = stall_c;
   assign bus.flush        = flush_c;
   assign bus.ex_bubble    = ex_bubble_c;
   assign bus.fetch_squash = fetch_squash_c;
   assign bus.issue_ok     = quiet | (outst_cnt < MAX_C);

   a_issue_over: assert property (@(posedge clk) disable iff (rst)
      !(bus.instr_issue && (outst_cnt >= MAX_C)));
   a_resp_under: assert property (@(posedge clk) disable iff (rst)
      !(bus.instr_resp && (outst_cnt == '0)));

endmodule

// File: tb/tb_hazard_ctrl_gen.sv
// Directed bench for hazard_ctrl_gen: each driven cycle pushes its expected
// outputs, which are popped and compared on the following falling edge.
module tb_hazard_ctrl_gen;

   typedef struct {
      string      tag;
      logic [3:0] stall;
      logic [2:0] flush;
      logic       bub;
      logic       sq;
      logic       iok;
   } exp_t;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   exp_t sb[$];

   hazard_ctrl_gen_if #(.NSTAGE(5), .REG_AW(5)) bus ();

   hazard_ctrl_gen #(
      .NSTAGE    (5),
      .REG_AW    (5),
      .LOAD_LAT  (2),
      .MAX_OUTST (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.jump         = 1'b0;
      bus.jump_reg     = 1'b0;
      bus.branch       = 1'b0;
      bus.int_req      = 1'b0;
      bus.ex_load      = 1'b0;
      bus.ex_rd_addr   = '0;
      bus.id_rs1_addr  = '0;
      bus.id_rs2_addr  = '0;
      bus.id_hazard_op = '0;
      bus.ex_busy      = 1'b0;
      bus.instr_issue  = 1'b0;
      bus.instr_resp   = 1'b0;
      bus.instr_wait   = 1'b0;
      bus.data_req     = 1'b0;
      bus.data_wait    = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic expect_out(input string tag, input logic [3:0] st, input logic [2:0] fl,
                             input logic bub, input logic sq, input logic iok);
      exp_t e;
      e.tag = tag; e.stall = st; e.flush = fl; e.bub = bub; e.sq = sq; e.iok = iok;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check_eq({e.tag, ".stall"}, 32'(bus.stall), 32'(e.stall));
         check_eq({e.tag, ".flush"}, 32'(bus.flush), 32'(e.flush));
         check_eq({e.tag, ".bubble"}, 32'(bus.ex_bubble), 32'(e.bub));
         check_eq({e.tag, ".squash"}, 32'(bus.fetch_squash), 32'(e.sq));
         check_eq({e.tag, ".issue_ok"}, 32'(bus.issue_ok), 32'(e.iok));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);

      // reset gating: hazards present while in reset and the cycle after
      #1; bus.int_req = 1; bus.branch = 1; bus.data_req = 1; bus.data_wait = 1;
      bus.ex_busy = 1; bus.instr_wait = 1;
      expect_out("rst_hold", 4'b0000, 3'b000, 0, 0, 1);
      cyc(); rst = 0; bus.int_req = 1; bus.branch = 1; bus.ex_busy = 1; bus.instr_wait = 1;
      expect_out("rst_after", 4'b0000, 3'b000, 0, 0, 1);
      cyc(); expect_out("idle", 4'b0000, 3'b000, 0, 0, 1);

      // load-use through EX then scoreboard entry
      cyc(); bus.ex_load = 1; bus.ex_rd_addr = 5; bus.id_rs1_addr = 5; bus.id_hazard_op = 2'b01;
      expect_out("lu_ex", 4'b0011, 3'b000, 1, 0, 1);
      cyc(); bus.id_rs1_addr = 5; bus.id_hazard_op = 2'b01;
      expect_out("lu_ent", 4'b0011, 3'b000, 1, 0, 1);
      cyc(); bus.id_rs1_addr = 5; bus.id_hazard_op = 2'b01;
      expect_out("lu_clr", 4'b0000, 3'b000, 0, 0, 1);
      cyc(); bus.ex_load = 1; bus.ex_rd_addr = 7; bus.id_rs1_addr = 3; bus.id_rs2_addr = 7;
      bus.id_hazard_op = 2'b10;
      expect_out("lu_rs2", 4'b0011, 3'b000, 1, 0, 1);
      cyc(); bus.id_rs1_addr = 3; bus.id_rs2_addr = 7; bus.id_hazard_op = 2'b01;
      expect_out("lu_rs2_off", 4'b0000, 3'b000, 0, 0, 1);
      cyc(); bus.ex_load = 1; bus.ex_rd_addr = 0; bus.id_rs1_addr = 0; bus.id_hazard_op = 2'b01;
      expect_out("lu_x0", 4'b0000, 3'b000, 0, 0, 1);
      cyc(); bus.id_hazard_op = 2'b11;
      expect_out("lu_x0_ent", 4'b0000, 3'b000, 0, 0, 1);

      // EX busy holds the scoreboard
      cyc(); bus.ex_load = 1; bus.ex_rd_addr = 9;
      expect_out("busy_pre", 4'b0000, 3'b000, 0, 0, 1);
      cyc(); bus.ex_busy = 1; expect_out("busy1", 4'b0111, 3'b000, 0, 0, 1);
      cyc(); bus.ex_busy = 1; expect_out("busy2", 4'b0111, 3'b000, 0, 0, 1);
      cyc(); bus.ex_busy = 1; bus.id_rs1_addr = 9; bus.id_hazard_op = 2'b01;
      expect_out("busy3", 4'b0111, 3'b000, 0, 0, 1);
      cyc(); bus.id_rs1_addr = 9; bus.id_hazard_op = 2'b01;
      expect_out("busy_keep", 4'b0011, 3'b000, 1, 0, 1);
      cyc(); bus.id_rs1_addr = 9; bus.id_hazard_op = 2'b01;
      expect_out("busy_done", 4'b0000, 3'b000, 0, 0, 1);

      // interrupt flush kills the EX load
      cyc(); bus.ex_load = 1; bus.ex_rd_addr = 4; bus.int_req = 1;
      expect_out("int_flush", 4'b0000, 3'b111, 0, 0, 1);
      cyc(); bus.id_rs1_addr = 4; bus.id_hazard_op = 2'b01;
      expect_out("int_kill", 4'b0000, 3'b000, 0, 0, 1);

      // counted squash after a branch with two fetches outstanding
      cyc(); bus.instr_issue = 1; expect_out("iss1", 4'b0000, 3'b000, 0, 0, 1);
      cyc(); bus.instr_issue = 1; expect_out("iss2", 4'b0000, 3'b000, 0, 0, 1);
      cyc(); bus.branch = 1; expect_out("br_flush", 4'b0000, 3'b011, 0, 0, 0);
      cyc(); bus.instr_resp = 1; expect_out("sq1", 4'b0001, 3'b000, 0, 1, 0);
      cyc(); bus.instr_resp = 1; bus.instr_issue = 1;
      expect_out("sq2", 4'b0001, 3'b000, 0, 1, 1);
      cyc(); bus.instr_resp = 1; expect_out("sq_done", 4'b0000, 3'b000, 0, 0, 1);
      cyc(); bus.instr_issue = 1; expect_out("iss3", 4'b0000, 3'b000, 0, 0, 1);
      cyc(); bus.jump_reg = 1; bus.instr_resp = 1;
      expect_out("resp_in_flush", 4'b0000, 3'b011, 0, 1, 1);
      cyc(); bus.instr_wait = 1; expect_out("iwait", 4'b0011, 3'b000, 0, 0, 1);
      cyc(); bus.instr_wait = 1; bus.jump = 1;
      expect_out("iwait_jump", 4'b0000, 3'b011, 0, 0, 1);

      // data stall defers a redirect
      cyc(); bus.data_req = 1; bus.data_wait = 1; bus.jump = 1; bus.int_req = 1;
      expect_out("dstall1", 4'b1111, 3'b000, 0, 0, 1);
      cyc(); bus.data_req = 1; bus.data_wait = 1; bus.jump = 1; bus.int_req = 1;
      expect_out("dstall2", 4'b1111, 3'b000, 0, 0, 1);
      cyc(); bus.data_req = 1; bus.jump = 1; bus.int_req = 1;
      expect_out("dstall_rel", 4'b0000, 3'b111, 0, 0, 1);
      cyc(); bus.data_wait = 1; expect_out("dwait_only", 4'b0000, 3'b000, 0, 0, 1);

      // reset in the middle of a squash
      cyc(); bus.instr_issue = 1; expect_out("r_iss1", 4'b0000, 3'b000, 0, 0, 1);
      cyc(); bus.instr_issue = 1; expect_out("r_iss2", 4'b0000, 3'b000, 0, 0, 1);
      cyc(); bus.branch = 1; expect_out("r_br", 4'b0000, 3'b011, 0, 0, 0);
      cyc(); bus.instr_resp = 1; expect_out("r_sq", 4'b0001, 3'b000, 0, 1, 0);
      cyc(); rst = 1; expect_out("r_rst", 4'b0000, 3'b000, 0, 0, 1);
      cyc(); rst = 0; expect_out("r_after", 4'b0000, 3'b000, 0, 0, 1);
      cyc(); expect_out("r_idle", 4'b0000, 3'b000, 0, 0, 1);
      cyc(); bus.instr_issue = 1; expect_out("r_iss_a", 4'b0000, 3'b000, 0, 0, 1);
      cyc(); bus.instr_issue = 1; expect_out("r_iss_b", 4'b0000, 3'b000, 0, 0, 1);
      cyc(); expect_out("r_full", 4'b0000, 3'b000, 0, 0, 0);
      cyc(); bus.instr_resp = 1; expect_out("r_resp1", 4'b0000, 3'b000, 0, 0, 0);
      cyc(); bus.instr_resp = 1; expect_out("r_resp2", 4'b0000, 3'b000, 0, 0, 1);
      cyc(); expect_out("end", 4'b0000, 3'b000, 0, 0, 1);

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) check_eq("drain", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
